// File: rtl/pb_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pb_pkg
//   Shared definitions for the push-button event arbiter.
//   - pb_state_t   : arbiter FSM states (IDLE / PRESENT / HOLDOFF)
//   - PB_N_BTN_DEF : default number of button inputs
//   - id_w()       : width of a button index, max(1, clog2(n))
// ---------------------------------------------------------------------------
package pb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } pb_state_t;

    localparam int PB_N_BTN_DEF = 4;

    // A single button still needs a 1-bit index.
    function automatic int id_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pb_event_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// pb_rr_select
//   Combinational round-robin picker. Finds the first set bit of `pending`
//   searching upward from `rr_ptr`, wrapping from N_BTN-1 back to 0.
//   Works for any N_BTN (no power-of-two assumption).
//
//   Ports:
//     pending     in  [N_BTN-1:0]  sticky pending flags
//     rr_ptr      in  [ID_W-1:0]   search start index (always < N_BTN)
//     any_pending out              at least one flag is set
//     sel_id      out [ID_W-1:0]   selected index (0 when nothing pending)
// ---------------------------------------------------------------------------
module pb_rr_select
    import pb_pkg::*;
#(
    parameter int N_BTN = PB_N_BTN_DEF,
    parameter int ID_W  = id_w(N_BTN)
) (
    input  logic [N_BTN-1:0] pending,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             any_pending,
    output logic [ID_W-1:0]  sel_id
);

    logic [2*N_BTN-1:0] doubled;
    logic [N_BTN-1:0]   rotated;
    logic               found;
    int                 pick;

    always_comb begin
        // Rotating a doubled copy right by rr_ptr puts index rr_ptr at bit 0;
        // the wrap then falls out naturally without needing N_BTN = 2^k.
        doubled     = {pending, pending} >> rr_ptr;
        rotated     = doubled[N_BTN-1:0];
        any_pending = |pending;
        found       = 1'b0;
        pick        = 0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                pick  = int'(rr_ptr) + k;
            end
        end
        if (pick >= N_BTN) begin
            pick = pick - N_BTN;
        end
        sel_id = ID_W'(pick);
    end

endmodule

// File: rtl/pb_event_arbiter.sv
// ---------------------------------------------------------------------------
// pb_event_arbiter
//   Collects one-cycle button pulses into sticky pending flags and serves
//   them round-robin as a single event stream, with a programmable idle gap
//   after each accepted event and a saturating count of dropped presses.
//
//   Ports:
//     clk        in                 system clock, rising edge
//     rst_n      in                 asynchronous active-low reset
//     pb_pulse   in  [N_BTN-1:0]    one-cycle press pulses, one per button
//     evt_valid  out                event presented
//     evt_ready  in                 consumer accepts the event
//     evt_id     out [ID_W-1:0]     index of the presented button
//     pending    out [N_BTN-1:0]    sticky pending flags
//     drop_cnt   out [DROP_W-1:0]   saturating count of dropped presses
//     clr_drop   in                 synchronous clear of drop_cnt
//     fsm_state  out pb_state_t     current arbiter state (observability)
//
//   Handshake: an event transfers on a rising edge where evt_valid and
//   evt_ready are both 1. Once raised, evt_valid and evt_id hold steady until
//   that transfer; evt_ready is don't-care while evt_valid is 0 and may be
//   tied high.
//
//   Every output is a flop: evt_ready and pb_pulse only affect next-state
//   logic.
// ---------------------------------------------------------------------------
module pb_event_arbiter
    import pb_pkg::*;
#(
    parameter int  N_BTN   = PB_N_BTN_DEF,
    parameter int  HOLDOFF = 16,
    parameter int  DROP_W  = 8,
    localparam int ID_W    = id_w(N_BTN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  pb_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic [N_BTN-1:0]  pending,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clr_drop,
    output pb_state_t         fsm_state
);

    // Hold-off counter only needs to reach HOLDOFF-1.
    localparam int HC_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    // Enough bits to count every button dropping in the same cycle.
    localparam int CNT_W = $clog2(N_BTN + 1);
    localparam int SUM_W = DROP_W + CNT_W;

    pb_state_t         state;
    pb_state_t         state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_nxt;
    logic [HC_W-1:0]   hold_cnt;
    logic [HC_W-1:0]   hold_cnt_nxt;
    logic              evt_valid_nxt;
    logic [ID_W-1:0]   evt_id_nxt;

    logic              any_pending;
    logic [ID_W-1:0]   sel_id;
    logic              handshake;
    logic              hold_done;

    logic [N_BTN-1:0]  clr_mask;
    logic [N_BTN-1:0]  drops;
    logic [N_BTN-1:0]  pending_nxt;
    logic [CNT_W-1:0]  drop_n;
    logic [SUM_W-1:0]  drop_base;
    logic [SUM_W-1:0]  drop_sum;
    logic [DROP_W-1:0] drop_cnt_nxt;

    pb_rr_select #(
        .N_BTN (N_BTN),
        .ID_W  (ID_W)
    ) u_rr_select (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .any_pending (any_pending),
        .sel_id      (sel_id)
    );

    assign handshake = evt_valid & evt_ready;
    assign hold_done = (int'(hold_cnt) >= HOLDOFF - 1);
    assign fsm_state = state;

    // -------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_pending) begin
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (handshake) begin
                    state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // FSM: outputs (next values of the registered event/pointer/counter)
    // -------------------------------------------------------------------
    always_comb begin
        evt_valid_nxt = evt_valid;
        evt_id_nxt    = evt_id;
        rr_ptr_nxt    = rr_ptr;
        hold_cnt_nxt  = hold_cnt;
        clr_mask      = '0;
        case (state)
            ST_IDLE: begin
                hold_cnt_nxt = '0;
                if (any_pending) begin
                    evt_valid_nxt = 1'b1;
                    evt_id_nxt    = sel_id;
                    for (int i = 0; i < N_BTN; i++) begin
                        clr_mask[i] = (sel_id == ID_W'(i));
                    end
                end
            end
            ST_PRESENT: begin
                if (handshake) begin
                    evt_valid_nxt = 1'b0;
                    hold_cnt_nxt  = '0;
                    rr_ptr_nxt    = (int'(evt_id) == N_BTN - 1) ? '0
                                                                : evt_id + ID_W'(1);
                end
            end
            ST_HOLDOFF: begin
                hold_cnt_nxt = hold_done ? '0 : hold_cnt + HC_W'(1);
            end
            default: begin
                evt_valid_nxt = 1'b0;
                hold_cnt_nxt  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------
    // Pending flags and drop counting
    // -------------------------------------------------------------------
    always_comb begin
        // A press on the button being cleared this cycle simply re-arms it;
        // only presses landing on a flag that stays set are drops.
        drops       = pb_pulse & pending & ~clr_mask;
        pending_nxt = (pending & ~clr_mask) | pb_pulse;

        drop_n = '0;
        for (int i = 0; i < N_BTN; i++) begin
            drop_n = drop_n + CNT_W'(drops[i]);
        end

        // Clearing restarts from zero but still records this cycle's drops.
        drop_base = clr_drop ? '0 : SUM_W'(drop_cnt);
        drop_sum  = drop_base + SUM_W'(drop_n);
        if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
            drop_cnt_nxt = '1;
        end else begin
            drop_cnt_nxt = drop_sum[DROP_W-1:0];
        end
    end

    // -------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            pending   <= '0;
            drop_cnt  <= '0;
        end else begin
            evt_valid <= evt_valid_nxt;
            evt_id    <= evt_id_nxt;
            rr_ptr    <= rr_ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            pending   <= pending_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pb_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pb_event_arbiter
//   dut_a : N_BTN=4, HOLDOFF=16, DROP_W=8  (vector table, reset mid-op)
//   dut_b : N_BTN=4, HOLDOFF=0,  DROP_W=2  (ordering, backpressure, drops)
//   dut_c : N_BTN=5, HOLDOFF=3,  DROP_W=3  (random vs. reference model)
// ---------------------------------------------------------------------------
module tb_pb_event_arbiter;
    import pb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rdy_a, clr_a, valid_a;
    logic [3:0] pb_a, pend_a;
    logic [1:0] id_a;
    logic [7:0] drop_a;
    pb_state_t  st_a;

    logic       rst_b_n, rdy_b, clr_b, valid_b;
    logic [3:0] pb_b, pend_b;
    logic [1:0] id_b;
    logic [1:0] drop_b;
    pb_state_t  st_b;

    logic       rst_c_n, rdy_c, clr_c, valid_c;
    logic [4:0] pb_c, pend_c;
    logic [2:0] id_c;
    logic [2:0] drop_c;
    pb_state_t  st_c;

    pb_event_arbiter #(.N_BTN(4), .HOLDOFF(16), .DROP_W(8)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .pb_pulse(pb_a), .evt_valid(valid_a),
        .evt_ready(rdy_a), .evt_id(id_a), .pending(pend_a), .drop_cnt(drop_a),
        .clr_drop(clr_a), .fsm_state(st_a)
    );

    pb_event_arbiter #(.N_BTN(4), .HOLDOFF(0), .DROP_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .pb_pulse(pb_b), .evt_valid(valid_b),
        .evt_ready(rdy_b), .evt_id(id_b), .pending(pend_b), .drop_cnt(drop_b),
        .clr_drop(clr_b), .fsm_state(st_b)
    );

    pb_event_arbiter #(.N_BTN(5), .HOLDOFF(3), .DROP_W(3)) dut_c (
        .clk(clk), .rst_n(rst_c_n), .pb_pulse(pb_c), .evt_valid(valid_c),
        .evt_ready(rdy_c), .evt_id(id_c), .pending(pend_c), .drop_cnt(drop_c),
        .clr_drop(clr_c), .fsm_state(st_c)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_b();
        rst_b_n = 1'b0;
        pb_b = '0; rdy_b = 1'b0; clr_b = 1'b0;
        tick();
        tick();
        rst_b_n = 1'b1;
    endtask

    // ---------------- vector table for dut_a ----------------
    typedef struct {
        logic [3:0] pb;
        logic       rdy;
        logic       clr;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic [3:0] exp_pend;
        logic [7:0] exp_drop;
    } vec_t;

    localparam int NV = 23;
    vec_t vt[NV];

    // ---------------- reference model state for dut_c ----------------
    localparam int MN = 5;
    localparam int MH = 3;
    localparam int MMAX = 7;
    logic [4:0] m_pend;
    bit         m_presented;
    int         m_id, m_gap, m_ptr, m_drops;

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        pb_a = '0; rdy_a = 1'b0; clr_a = 1'b0;
        pb_b = '0; rdy_b = 1'b0; clr_b = 1'b0;
        pb_c = '0; rdy_c = 1'b0; clr_c = 1'b0;
        tick();
        tick();

        // ---------- reset values ----------
        check("rst_valid", valid_a, 0);
        check("rst_id",    id_a,    0);
        check("rst_pend",  pend_a,  0);
        check("rst_drop",  drop_a,  0);
        check("rst_state", st_a,    ST_IDLE);
        rst_a_n = 1'b1;

        // ---------- table: single press + 16-cycle gap + drop + clear ----------
        for (int i = 0; i < NV; i++) begin
            vt[i] = '{pb: 4'b0000, rdy: 1'b1, clr: 1'b0, exp_valid: 1'b0,
                      exp_id: 2'd0, exp_pend: 4'b0000, exp_drop: 8'd0};
        end
        vt[1].pb = 4'b0100;  vt[1].exp_pend = 4'b0100;
        vt[2].exp_valid = 1'b1; vt[2].exp_id = 2'd2;
        // vt[3]: handshake edge (h)
        vt[4].pb = 4'b0001;  vt[4].exp_pend = 4'b0001;
        vt[5].pb = 4'b0001;  vt[5].exp_pend = 4'b0001; vt[5].exp_drop = 8'd1;
        for (int i = 6; i < 20; i++) begin
            vt[i].exp_pend = 4'b0001;
            vt[i].exp_drop = 8'd1;
        end
        // vt[19] is edge h+16: back to IDLE; first event possible at h+17
        vt[20].exp_valid = 1'b1; vt[20].exp_id = 2'd0; vt[20].exp_drop = 8'd1;
        vt[21].exp_drop = 8'd1;
        vt[22].clr = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pb_a  = vt[i].pb;
            rdy_a = vt[i].rdy;
            clr_a = vt[i].clr;
            tick();
            check($sformatf("vec%0d_valid", i), valid_a, vt[i].exp_valid);
            if (vt[i].exp_valid) begin
                check($sformatf("vec%0d_id", i), id_a, vt[i].exp_id);
            end
            check($sformatf("vec%0d_pend", i), pend_a, vt[i].exp_pend);
            check($sformatf("vec%0d_drop", i), drop_a, vt[i].exp_drop);
        end
        pb_a = '0; clr_a = 1'b0;

        // ---------- simultaneous presses, HOLDOFF=0 ----------
        begin
            int got[$];
            int at[$];
            int seen;
            reset_b();
            rdy_b = 1'b1;
            pb_b = 4'b1011;
            tick();
            pb_b = 4'b0000;
            check("sim_pend", pend_b, 4'b1011);
            exp_q = '{2'd0, 2'd1, 2'd3};
            for (int c = 0; c < 20 && got.size() < 3; c++) begin
                tick();
                if (valid_b) begin
                    got.push_back(int'(id_b));
                    at.push_back(c);
                end
            end
            check("sim_count", got.size(), 3);
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got.size()) begin
                    check($sformatf("sim_order%0d", i), got[i], exp_q[i]);
                end
            end
            for (int i = 1; i < got.size(); i++) begin
                check($sformatf("sim_gap%0d", i), at[i] - at[i-1], 2);
            end
            tick();
            tick();
            // rr_ptr must have wrapped to 0: from 0, button 1 comes before 3
            pb_b = 4'b1010;
            tick();
            pb_b = 4'b0000;
            seen = 0;
            for (int c = 0; c < 5 && seen == 0; c++) begin
                tick();
                if (valid_b) begin
                    seen = 1;
                    check("rr_wrap_id", id_b, 1);
                end
            end
            check("rr_wrap_seen", seen, 1);
        end

        // ---------- re-press in the cycle of selection ----------
        reset_b();
        pb_b = 4'b0100;
        tick();
        tick();
        pb_b = 4'b0000;
        check("repress_valid", valid_b, 1);
        check("repress_id",    id_b,    2);
        check("repress_pend",  pend_b,  4'b0100);
        check("repress_drop",  drop_b,  0);

        // ---------- backpressure, then drops and saturation ----------
        reset_b();
        pb_b = 4'b0010;
        tick();
        pb_b = 4'b0000;
        tick();
        for (int c = 0; c < 50; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), {valid_b, id_b}, 3'b101);
        end
        for (int c = 0; c < 3; c++) begin
            pb_b = 4'b0010;
            tick();
        end
        pb_b = 4'b0000;
        check("bp_pend1", pend_b[1], 1);
        check("bp_drop",  drop_b,    2);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("clr_alone", drop_b, 0);
        for (int c = 0; c < 5; c++) begin
            pb_b = 4'b0010;
            tick();
        end
        check("sat_drop", drop_b, 3);
        clr_b = 1'b1;
        tick();
        pb_b = 4'b0000;
        clr_b = 1'b0;
        check("clr_with_drop", drop_b, 1);
        rdy_b = 1'b1;
        tick();
        check("bp_release_valid", valid_b, 0);
        tick();
        check("bp_next_valid", valid_b, 1);
        check("bp_next_id",    id_b,    1);

        // ---------- reset mid-operation ----------
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        rdy_a = 1'b0;
        pb_a = 4'b0001;
        tick();
        pb_a = 4'b0000;
        tick();
        pb_a = 4'b1100;
        tick();
        pb_a = 4'b0100;
        tick();
        pb_a = 4'b0000;
        check("mid_present", valid_a, 1);
        check("mid_pend",    pend_a,  4'b1100);
        check("mid_drop",    drop_a,  1);
        rst_a_n = 1'b0;
        #1;
        check("mid_async_valid", valid_a, 0);
        tick();
        rst_a_n = 1'b1;
        tick();
        check("post_rst_pend",  pend_a,  0);
        check("post_rst_drop",  drop_a,  0);
        check("post_rst_state", st_a,    ST_IDLE);
        check("post_rst_valid", valid_a, 0);

        // ---------- random stimulus vs. reference model (dut_c) ----------
        rst_c_n = 1'b1;
        m_pend = '0; m_presented = 0; m_id = 0; m_gap = 0; m_ptr = 0; m_drops = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int sel;
            int d;
            bit hs;
            for (int i = 0; i < MN; i++) begin
                pb_c[i] = ($urandom_range(0, 5) == 0);
            end
            rdy_c = ($urandom_range(0, 2) != 0);
            clr_c = ($urandom_range(0, 30) == 0);

            sel = -1;
            if (!m_presented && m_gap == 0) begin
                for (int k = 0; k < MN; k++) begin
                    int j;
                    j = (m_ptr + k) % MN;
                    if (sel < 0 && m_pend[j]) sel = j;
                end
            end
            d = 0;
            for (int i = 0; i < MN; i++) begin
                if (pb_c[i] && m_pend[i] && i != sel) d++;
            end
            hs = m_presented && rdy_c;
            for (int i = 0; i < MN; i++) begin
                if (i == sel) m_pend[i] = 1'b0;
                if (pb_c[i])  m_pend[i] = 1'b1;
            end
            m_drops = clr_c ? d : m_drops + d;
            if (m_drops > MMAX) m_drops = MMAX;
            if (hs) begin
                m_presented = 0;
                m_ptr = (m_id + 1) % MN;
                m_gap = MH;
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (sel >= 0) begin
                m_presented = 1;
                m_id = sel;
            end

            tick();
            check($sformatf("rnd%0d_valid", cyc), valid_c, m_presented);
            if (m_presented) begin
                check($sformatf("rnd%0d_id", cyc), id_c, m_id);
            end
            check($sformatf("rnd%0d_pend", cyc), pend_c, m_pend);
            check($sformatf("rnd%0d_drop", cyc), drop_c, m_drops);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
